// File: rtl/alu_op_sequencer.sv
// Clocked command front-end for a combinational 4-bit ALU: issues registered operands,
// waits a fixed settle time, captures the result and returns it on a valid/ready port.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_src_acc,
  input  logic       cmd_wr_acc,
  input  logic       acc_clr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic [3:0] acc_out,
  output logic [7:0] op_count
);

  localparam int unsigned DW   = 4;
  localparam int unsigned OPW  = 3;
  localparam int unsigned CNTW = 4;
  localparam int unsigned OCW  = 8;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [CNTW-1:0] r_cnt;
  logic            r_wr_acc;
  logic [DW-1:0]   r_alu_a;
  logic [DW-1:0]   r_alu_b;
  logic [OPW-1:0]  r_alu_op;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_result;
  logic            r_rsp_zero;
  logic            r_rsp_carry;
  logic [DW-1:0]   r_acc;
  logic [OCW-1:0]  r_op_count;
  logic            w_accept;
  logic            w_capture;
  logic            w_rsp_hs;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign w_capture = (r_state == S_SETTLE) && (r_cnt == '0);
  assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_next_state = S_SETTLE;
      S_SETTLE: if (r_cnt == '0) w_next_state = S_RESP;
      S_RESP:   if (rsp_ready) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Issue, settle countdown, capture and response hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_wr_acc     <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_carry  <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= cmd_src_acc ? r_acc : cmd_a;
        r_alu_b  <= cmd_b;
        r_alu_op <= cmd_op;
        r_wr_acc <= cmd_wr_acc;
        r_cnt    <= CNT_INIT;
      end else if ((r_state == S_SETTLE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNTW'(1);
      end
      if (w_capture) begin
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
        r_rsp_carry  <= alu_carry;
        r_rsp_valid  <= 1'b1;
        r_op_count   <= r_op_count + OCW'(1);
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Accumulator: clear has priority over a capture write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_acc <= '0;
    else if (acc_clr)              r_acc <= '0;
    else if (w_capture && r_wr_acc) r_acc <= alu_result;
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_carry  = r_rsp_carry;
  assign acc_out    = r_acc;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural 4-bit ALU as responder, table-driven vectors
// with a response scoreboard, plus hand-written handshake, clear and reset sequences.
module tb_alu_op_sequencer;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       src;
    logic       wr;
    logic       clr;
    logic [3:0] r;
    logic       z;
    logic       c;
    logic [3:0] acc;
  } vec_t;

  typedef struct {
    logic [3:0] r;
    logic       z;
    logic       c;
    logic [3:0] acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // SETTLE_CYCLES=1 instance
  logic       cmd_valid = 0, cmd_ready, cmd_src_acc = 0, cmd_wr_acc = 0, acc_clr = 0;
  logic [2:0] cmd_op = 0, alu_op;
  logic [3:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_result, rsp_result, acc_out;
  logic       alu_zero, alu_carry, rsp_valid, rsp_ready = 0, rsp_zero, rsp_carry;
  logic [7:0] op_count;

  // SETTLE_CYCLES=4 instance
  logic       c4_valid = 0, c4_ready, c4_src_acc = 0, c4_wr_acc = 0, c4_acc_clr = 0;
  logic [2:0] c4_op = 0, a4_op;
  logic [3:0] c4_a = 0, c4_b = 0, a4_a, a4_b, a4_result, r4_result, acc4_out;
  logic       a4_zero, a4_carry, r4_valid, r4_ready = 1, r4_zero, r4_carry;
  logic [7:0] op4_count;

  alu_op_sequencer #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_src_acc(cmd_src_acc),
    .cmd_wr_acc(cmd_wr_acc), .acc_clr(acc_clr), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .acc_out(acc_out), .op_count(op_count)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c4_valid), .cmd_ready(c4_ready),
    .cmd_op(c4_op), .cmd_a(c4_a), .cmd_b(c4_b), .cmd_src_acc(c4_src_acc),
    .cmd_wr_acc(c4_wr_acc), .acc_clr(c4_acc_clr), .alu_a(a4_a), .alu_b(a4_b),
    .alu_op(a4_op), .alu_result(a4_result), .alu_zero(a4_zero), .alu_carry(a4_carry),
    .rsp_valid(r4_valid), .rsp_ready(r4_ready), .rsp_result(r4_result),
    .rsp_zero(r4_zero), .rsp_carry(r4_carry), .acc_out(acc4_out), .op_count(op4_count)
  );

  function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    logic [3:0] r;
    logic       c;
    logic [4:0] s;
    r = 4'd0; c = 1'b0; s = 5'd0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = a ^ b;
      3'b011: r = ~a;
      3'b100: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
      3'b101: begin r = a - b; c = (a < b); end
      3'b110: begin r = {a[2:0], 1'b0}; c = a[3]; end
      default: begin r = {1'b0, a[3:1]}; c = a[0]; end
    endcase
    return {c, (r == 4'd0), r};
  endfunction

  always_comb {alu_carry, alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);
  always_comb {a4_carry, a4_zero, a4_result}    = alu_f(a4_op, a4_a, a4_b);

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  exp_t sb[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic src, input logic wr, input logic clr);
    int n;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_src_acc = src; cmd_wr_acc = wr;
    cmd_valid = 1'b1; acc_clr = clr;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic push(input logic [3:0] r, input logic z, input logic c, input logic [3:0] acc);
    exp_t e;
    e.r = r; e.z = z; e.c = c; e.acc = acc;
    sb.push_back(e);
  endtask

  // Wait for a response, compare with the scoreboard head, then complete the handshake
  task automatic get_rsp(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    if (!rsp_valid) begin
      chk({name, "_timeout"}, 32'(rsp_valid), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk({name, "_unexpected"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({name, "_result"}, 32'({rsp_zero, rsp_carry, rsp_result}), 32'({e.z, e.c, e.r}));
    chk({name, "_acc"}, 32'(acc_out), 32'(e.acc));
    exp_cnt++;
    rsp_ready = 1'b1;
    tick();
  endtask

  initial begin
    exp_t e;
    int   hits;
    vecs[0]  = '{3'b101, 4'b0011, 4'b0111, 0, 0, 0, 4'b1100, 0, 1, 4'b0000};
    vecs[1]  = '{3'b100, 4'b1111, 4'b0001, 0, 0, 0, 4'b0000, 1, 1, 4'b0000};
    vecs[2]  = '{3'b000, 4'b1100, 4'b1010, 0, 0, 0, 4'b1000, 0, 0, 4'b0000};
    vecs[3]  = '{3'b001, 4'b1100, 4'b1010, 0, 0, 0, 4'b1110, 0, 0, 4'b0000};
    vecs[4]  = '{3'b010, 4'b1100, 4'b1010, 0, 0, 0, 4'b0110, 0, 0, 4'b0000};
    vecs[5]  = '{3'b011, 4'b0101, 4'b0000, 0, 0, 0, 4'b1010, 0, 0, 4'b0000};
    vecs[6]  = '{3'b111, 4'b0101, 4'b0000, 0, 0, 0, 4'b0010, 0, 1, 4'b0000};
    vecs[7]  = '{3'b101, 4'b0101, 4'b0101, 0, 0, 0, 4'b0000, 1, 0, 4'b0000};
    vecs[8]  = '{3'b100, 4'b0011, 4'b0001, 0, 1, 0, 4'b0100, 0, 0, 4'b0100};
    vecs[9]  = '{3'b100, 4'b1111, 4'b0101, 1, 1, 1, 4'b0101, 0, 0, 4'b0101};
    vecs[10] = '{3'b100, 4'b1111, 4'b0101, 1, 1, 0, 4'b1010, 0, 0, 4'b1010};
    vecs[11] = '{3'b110, 4'b0000, 4'b0000, 1, 1, 0, 4'b0100, 0, 1, 4'b0100};

    #3;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_outputs", 32'({rsp_valid, acc_out, op_count, alu_a, alu_b, alu_op}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD with single-cycle settle: response one edge after accept
    rsp_ready = 1'b1;
    send(3'b100, 4'b0111, 4'b0011, 0, 0, 0);
    push(4'b1010, 0, 0, 4'b0000);
    chk("lat_accept_edge", 32'({rsp_valid, cmd_ready}), 32'd0);
    tick();
    chk("lat_one_edge", 32'(rsp_valid), 32'd1);
    get_rsp("add_first");
    chk("op_count_first", 32'(op_count), 32'd1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].clr) begin
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk($sformatf("vec%0d_clr", i), 32'(acc_out), 32'd0);
      end
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].src, vecs[i].wr, 1'b0);
      push(vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].acc);
      get_rsp($sformatf("vec%0d", i));
    end

    // Back-pressure: response held, new command stalled until one cycle after handshake
    rsp_ready = 1'b0;
    send(3'b100, 4'b0001, 4'b0001, 0, 0, 0);
    push(4'b0010, 0, 0, 4'b0100);
    hits = 0;
    while (!rsp_valid && hits < 20) begin tick(); hits++; end
    cmd_op = 3'b010; cmd_a = 4'b1111; cmd_b = 4'b0101; cmd_src_acc = 0; cmd_wr_acc = 0;
    cmd_valid = 1'b1;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d", i), 32'({rsp_valid, cmd_ready, rsp_zero, rsp_carry, rsp_result}),
          32'({1'b1, 1'b0, e.z, e.c, e.r}));
      tick();
    end
    exp_cnt++;
    rsp_ready = 1'b1;
    tick();
    chk("hold_release", 32'({rsp_valid, cmd_ready}), 32'b01);
    tick();
    cmd_valid = 1'b0;
    chk("hold_accept", 32'({cmd_ready, alu_a, alu_b, alu_op}), 32'({1'b0, 4'b1111, 4'b0101, 3'b010}));
    push(4'b1010, 0, 0, 4'b0100);
    get_rsp("hold_next");

    // Clear coinciding with a capture write: clear wins
    send(3'b100, 4'b0101, 4'b0101, 0, 1, 0);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    push(4'b1010, 0, 0, 4'b0000);
    get_rsp("clr_vs_wr");

    // Source from acc on the clear edge sees the pre-clear value
    send(3'b100, 4'b0011, 4'b0000, 0, 1, 0);
    push(4'b0011, 0, 0, 4'b0011);
    get_rsp("acc_load");
    send(3'b001, 4'b1111, 4'b0000, 1, 0, 1);
    chk("src_preclear", 32'({alu_a, acc_out}), 32'({4'b0011, 4'b0000}));
    push(4'b0011, 0, 0, 4'b0000);
    get_rsp("src_preclear_rsp");
    chk("op_count_total", 32'(op_count), 32'(exp_cnt));

    // SETTLE_CYCLES=4: latency, then reset mid-settle
    c4_op = 3'b100; c4_a = 4'b0110; c4_b = 4'b0001; c4_wr_acc = 1'b1; c4_valid = 1'b1;
    tick();
    c4_valid = 1'b0;
    repeat (3) tick();
    chk("s4_not_yet", 32'(r4_valid), 32'd0);
    tick();
    chk("s4_rsp", 32'({r4_valid, r4_result, acc4_out}), 32'({1'b1, 4'b0111, 4'b0111}));
    tick();
    c4_op = 3'b000; c4_a = 4'b1111; c4_b = 4'b1111; c4_wr_acc = 1'b1; c4_valid = 1'b1;
    tick();
    c4_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("s4_reset_async", 32'({r4_valid, c4_ready, acc4_out, a4_a, a4_b, a4_op}),
        32'({1'b0, 1'b1, 15'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (r4_valid) hits++;
    end
    chk("s4_dropped", 32'(hits), 32'd0);
    chk("s4_count_after_reset", 32'(op4_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
